cyx_load_ext_pipe: RTL

Parametrised, pipelined successor to the CPU's 16-to-32-bit immediate extender. It selects a byte, halfword or full word from a `DATA_W`-bit memory word using the low address bits, then zero- or sign-extends it or applies LUI placement. Results pass through a 2-entry valid/ready skid buffer. It sits between the data-memory read port and register-file write-back, and also serves the immediate path (LUI, signed and unsigned immediates) when the datapath is pipelined.

---
 rtl/cyx_ext_pkg.sv | 66 ++++++
 rtl/cyx_load_ext_pipe_if.sv | 28 ++
 rtl/cyx_skid_buf2.sv | 95 +++++++++
 rtl/cyx_load_ext_pipe.sv | 42 ++++
 4 files changed

// File: rtl/cyx_ext_pkg.sv
// Shared definitions for the load/immediate extension pipe.
// Holds the mode encodings, the skid-buffer state type and ext_word(),
// the width-generic extension function returning {err, dout}.
package cyx_ext_pkg;

    localparam int unsigned MODE_W    = 3;
    localparam int unsigned MAX_W     = 256;
    localparam int unsigned MAX_OFF_W = $clog2(MAX_W / 8);

    localparam logic [MODE_W-1:0] MODE_ZB  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_SB  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_ZH  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SH  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_W32 = 3'd4;
    localparam logic [MODE_W-1:0] MODE_LUI = 3'd5;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    // Extends a word of data_w bits (held in the low bits of din) and
    // returns {err, dout}; bits of dout at or above data_w are always 0.
    function automatic logic [MAX_W:0] ext_word(
        input int unsigned         data_w,
        input logic [MODE_W-1:0]   mode,
        input logic [MAX_OFF_W-1:0] offset,
        input logic [MAX_W-1:0]    din
    );
        logic [MAX_W-1:0] shifted;
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] res;
        logic             bad;
        int unsigned      half;
        half    = data_w / 2;
        shifted = din >> {offset, 3'b000};
        mask    = (data_w >= MAX_W) ? {MAX_W{1'b1}}
                                    : ((MAX_W'(1) << data_w) - MAX_W'(1));
        res     = '0;
        bad     = 1'b0;
        case (mode)
            MODE_ZB:  res = MAX_W'(shifted[7:0]);
            MODE_SB:  res = {{(MAX_W-8){shifted[7]}}, shifted[7:0]};
            MODE_ZH: begin
                bad = offset[0];
                res = MAX_W'(shifted[15:0]);
            end
            MODE_SH: begin
                bad = offset[0];
                res = {{(MAX_W-16){shifted[15]}}, shifted[15:0]};
            end
            MODE_W32: begin
                bad = (offset != '0);
                res = din;
            end
            MODE_LUI: res = (din & (mask >> half)) << half;
            default:  bad = 1'b1;
        endcase
        if (bad) begin
            res = '0;
        end
        return {bad, res & mask};
    endfunction

endpackage

// File: rtl/cyx_load_ext_pipe_if.sv
// Valid/ready bus of the extension pipe.
// master: producer/consumer side (drives in_valid, mode, offset, din, out_ready)
// slave:  the pipe (drives in_ready, out_valid, dout, err)
interface cyx_load_ext_pipe_if #(
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        mode;
    logic [OFF_W-1:0]  offset;
    logic [DATA_W-1:0] din;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] dout;
    logic              err;

    modport master (
        output in_valid, mode, offset, din, out_ready,
        input  in_ready, out_valid, dout, err
    );

    modport slave (
        input  in_valid, mode, offset, din, out_ready,
        output in_ready, out_valid, dout, err
    );
endinterface

// File: rtl/cyx_skid_buf2.sv
// Two-entry valid/ready FIFO buffer with registered in_ready/out_valid.
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_data push side;
// out_valid/out_ready/out_data pop side, out_data is the head entry.
module cyx_skid_buf2
    import cyx_ext_pkg::*;
#(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_e   state;
    buf_state_e   state_next;
    logic         push_c;
    logic         pop_c;
    logic         head_ld_c;
    logic         head_from_tail_c;
    logic         tail_ld_c;
    logic [W-1:0] tail_q;

    assign push_c = in_valid & in_ready;
    assign pop_c  = out_valid & out_ready;

    // State register; handshake flags are precomputed from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BUF_EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next != BUF_FULL);
            out_valid <= (state_next != BUF_EMPTY);
        end
    end

    // Occupancy transitions.
    always_comb begin
        state_next = state;
        case (state)
            BUF_EMPTY: if (push_c) state_next = BUF_ONE;
            BUF_ONE: begin
                if (push_c && !pop_c) begin
                    state_next = BUF_FULL;
                end else if (!push_c && pop_c) begin
                    state_next = BUF_EMPTY;
                end
            end
            BUF_FULL:  if (pop_c) state_next = BUF_ONE;
            default:   state_next = BUF_EMPTY;
        endcase
    end

    // Storage load controls; push+pop in ONE overwrites the head directly.
    always_comb begin
        head_ld_c        = 1'b0;
        head_from_tail_c = 1'b0;
        tail_ld_c        = 1'b0;
        case (state)
            BUF_EMPTY: head_ld_c = push_c;
            BUF_ONE: begin
                head_ld_c = push_c & pop_c;
                tail_ld_c = push_c & ~pop_c;
            end
            BUF_FULL: begin
                head_ld_c        = pop_c;
                head_from_tail_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            tail_q   <= '0;
        end else begin
            if (head_ld_c) begin
                out_data <= head_from_tail_c ? tail_q : in_data;
            end
            if (tail_ld_c) begin
                tail_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/cyx_load_ext_pipe.sv
// Byte/halfword/word select with zero/sign extension or LUI placement,
// followed by a 2-entry skid buffer holding {err, dout}.
// Ports: clk, rst (sync, active high); bus (slave): in_valid/in_ready,
// mode, offset, din in; out_valid/out_ready, dout, err out.
module cyx_load_ext_pipe
    import cyx_ext_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    cyx_load_ext_pipe_if.slave  bus
);

    logic [MAX_W:0]  ext_c;
    logic [DATA_W:0] buf_din_c;
    logic [DATA_W:0] buf_dout;

    // Extension result; bits between DATA_W and MAX_W are zero by construction.
    always_comb begin
        ext_c = ext_word(DATA_W, bus.mode, MAX_OFF_W'(bus.offset), MAX_W'(bus.din));
    end

    assign buf_din_c = {ext_c[MAX_W], DATA_W'(ext_c)};

    cyx_skid_buf2 #(
        .W (DATA_W + 1)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (buf_din_c),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (buf_dout)
    );

    assign bus.err  = buf_dout[DATA_W];
    assign bus.dout = buf_dout[DATA_W-1:0];

endmodule
